// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: buffers a weight tile, pushes it down the top edge, then streams skewed activations onto the left edge (macro SYSTOLIC_FEEDER_STALL_CNT_EN adds a stall counter; ports: clk/rst, start+count, weight and activation ready/valid inputs, mode/top/left edge drives, busy/done/stall status)
module systolic_edge_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int MUL_BW = 16,
  parameter int ADD_BW = 32,
  parameter int CNT_BW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [CNT_BW-1:0]        i_num_vec,
  input  logic                     i_w_valid,
  output logic                     o_w_ready,
  input  logic [COLS*MUL_BW-1:0]   i_w_data,
  input  logic                     i_a_valid,
  output logic                     o_a_ready,
  input  logic [ROWS*MUL_BW-1:0]   i_a_data,
  output logic                     o_mode,
  output logic [COLS*ADD_BW-1:0]   o_top,
  output logic [ROWS*MUL_BW-1:0]   o_left,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [31:0]              o_stall_cnt
);
  localparam int IW = $clog2(ROWS);
  localparam int CW = IW + 1;
  localparam int DW = $clog2(ROWS + COLS) + 1;
  typedef enum logic [2:0] {IDLE, WFILL, WPUSH, STREAM, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_BW-1:0] nv, vcnt;
  logic [CW-1:0] wcnt, pcnt;
  logic [DW-1:0] dcnt;
  logic [IW-1:0] pidx;
  logic [COLS*MUL_BW-1:0] wbuf [ROWS];
  logic [ROWS*MUL_BW-1:0] in_reg;
  logic accept, last, shift;
  function automatic logic [COLS*ADD_BW-1:0] widen(input logic [COLS*MUL_BW-1:0] w);
    logic [COLS*ADD_BW-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*ADD_BW +: ADD_BW] = ADD_BW'(w[c*MUL_BW +: MUL_BW]);
    return r;
  endfunction
  assign accept = i_a_valid && o_a_ready;
  assign last = accept && (vcnt + CNT_BW'(1) == nv);
  assign shift = (state == STREAM) || (state == DRAIN);
  // entry feeding the next push cycle; the newest entry goes out first so entry k lands in row k
  assign pidx = IW'(CW'(ROWS - 2) - pcnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nv <= '0;
      vcnt <= '0;
      wcnt <= '0;
      pcnt <= '0;
      dcnt <= '0;
      in_reg <= '0;
      o_mode <= 1'b0;
      o_top <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_w_ready <= 1'b0;
      o_a_ready <= 1'b0;
      for (int k = 0; k < ROWS; k++) wbuf[k] <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state <= WFILL;
          nv <= i_num_vec;
          wcnt <= '0;
          o_w_ready <= 1'b1;
          o_busy <= 1'b1;
        end
        WFILL: if (i_w_valid) begin
          wbuf[wcnt[IW-1:0]] <= i_w_data;
          wcnt <= wcnt + CW'(1);
          if (wcnt == CW'(ROWS - 1)) begin
            state <= WPUSH;
            o_w_ready <= 1'b0;
            pcnt <= '0;
            o_top <= widen(i_w_data);
          end
        end
        WPUSH: begin
          pcnt <= pcnt + CW'(1);
          if (pcnt == CW'(ROWS - 1)) begin
            o_top <= '0;
            o_mode <= 1'b1;
            vcnt <= '0;
            dcnt <= '0;
            state <= (nv == '0) ? DRAIN : STREAM;
            o_a_ready <= (nv != '0);
          end else o_top <= widen(wbuf[pidx]);
        end
        STREAM: begin
          in_reg <= accept ? i_a_data : '0;
          if (accept) vcnt <= (&vcnt) ? vcnt : vcnt + CNT_BW'(1);
          if (last) begin
            state <= DRAIN;
            o_a_ready <= 1'b0;
          end
        end
        DRAIN: begin
          in_reg <= '0;
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(ROWS + COLS - 2)) begin
            state <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          o_done <= 1'b0;
          o_mode <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_left[0 +: MUL_BW] = in_reg[0 +: MUL_BW];
  for (genvar r = 1; r < ROWS; r++) begin : g_lane
    logic [MUL_BW-1:0] sr [r];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < r; k++) sr[k] <= '0;
      end else if (shift) begin
        sr[0] <= in_reg[r*MUL_BW +: MUL_BW];
        for (int k = 1; k < r; k++) sr[k] <= sr[k-1];
      end
    end
    assign o_left[r*MUL_BW +: MUL_BW] = sr[r-1];
  end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && i_start)) stall <= '0;
    else if (state == STREAM && o_a_ready && !i_a_valid && !(&stall)) stall <= stall + 32'd1;
  end
  assign o_stall_cnt = stall;
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: table-driven directed checks of weight load/push, skewed streaming, drain, done and reset
module tb_systolic_edge_feeder;
  logic clk = 1'b0;
  logic rst, i_start, i_w_valid, i_a_valid;
  logic [15:0] i_num_vec;
  logic [63:0] i_w_data, i_a_data, o_left;
  logic o_w_ready, o_a_ready, o_mode, o_busy, o_done;
  logic [127:0] o_top;
  logic [31:0] o_stall_cnt;
  int nchk = 0, nfail = 0, cyc = 0;
  typedef struct {
    logic [15:0] nv;
    logic [63:0] wb;
    logic [15:0] wstep;
    logic [3:0] gap;
    logic [15:0] abase, astep, idle;
    logic hold;
    logic [127:0] top0;
    logic [31:0] stall;
  } case_t;
  case_t tc [4];
  logic [63:0] rec [int];
  systolic_edge_feeder dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_vec(i_num_vec),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_data(i_a_data),
    .o_mode(o_mode), .o_top(o_top), .o_left(o_left), .o_busy(o_busy),
    .o_done(o_done), .o_stall_cnt(o_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  function automatic logic [127:0] push_top(input logic [63:0] wb, input logic [15:0] ws, input int j);
    logic [127:0] r;
    logic [15:0] b;
    r = '0;
    b = wb[(3-j)*16 +: 16];
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = {16'h0, b + 16'(c) * ws};
    return r;
  endfunction
  function automatic logic [63:0] avec(input case_t c, input int a);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = c.abase + c.astep * 16'(a * 4 + l);
    return r;
  endfunction
  task automatic load_w(input logic [63:0] wb, input logic [15:0] ws, input logic [3:0] gap);
    for (int k = 0; k < 4; k++) begin
      if (gap[k]) begin
        i_w_valid = 1'b0;
        tick();
        chk("w_ready_gap", 128'(o_w_ready), 128'(1));
      end
      i_w_valid = 1'b1;
      for (int c = 0; c < 4; c++) i_w_data[c*16 +: 16] = wb[k*16 +: 16] + 16'(c) * ws;
      tick();
    end
    i_w_valid = 1'b0;
  endtask
  task automatic run_case(input int t);
    case_t c;
    int acc, sidx, q, exp_done;
    logic v, done_seen;
    logic [63:0] exp_left;
    logic [31:0] exp_st;
    c = tc[t];
    rec.delete();
    acc = 0;
    sidx = 0;
    i_num_vec = c.nv;
    i_start = 1'b1;
    tick();
    chk("start_busy", 128'(o_busy), 128'(1));
    chk("start_w_ready", 128'(o_w_ready), 128'(1));
    if (!c.hold) i_start = 1'b0;
    load_w(c.wb, c.wstep, c.gap);
    chk("push_w_ready", 128'(o_w_ready), 128'(0));
    chk("push_top0", o_top, c.top0);
    chk("push_mode", 128'(o_mode), 128'(0));
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("push_top", o_top, push_top(c.wb, c.wstep, j));
      chk("push_mode", 128'(o_mode), 128'(0));
    end
    q = cyc;
    exp_done = (c.nv == 0) ? q + 8 : -1;
    tick();
    done_seen = 1'b0;
    for (int g = 0; g < 200 && !done_seen; g++) begin
      exp_left = '0;
      for (int r = 0; r < 4; r++) if (rec.exists(cyc - r)) exp_left[r*16 +: 16] = rec[cyc - r][r*16 +: 16];
      chk("left", 128'(o_left), 128'(exp_left));
      chk("done", 128'(o_done), 128'(cyc == exp_done));
      if (cyc == exp_done) begin
        done_seen = 1'b1;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        exp_st = c.stall;
`else
        exp_st = 32'd0;
`endif
        chk("stall_cnt", 128'(o_stall_cnt), 128'(exp_st));
      end else begin
        chk("mode_mac", 128'(o_mode), 128'(1));
        chk("top_zero", o_top, 128'(0));
        chk("a_ready", 128'(o_a_ready), 128'(acc < int'(c.nv)));
        v = 1'b0;
        if (acc < int'(c.nv)) begin
          v = !(sidx < 16 && c.idle[sidx]);
          sidx++;
        end
        i_a_valid = v;
        i_a_data = avec(c, acc);
        if (v) begin
          rec[cyc + 1] = i_a_data;
          acc++;
          if (acc == int'(c.nv)) exp_done = cyc + 1 + 7;
        end
        tick();
      end
    end
    i_a_valid = 1'b0;
    if (!done_seen) begin
      nchk++;
      nfail++;
      $display("FAIL done_timeout case %0d: got no o_done expected pulse", t);
    end
    tick();
    chk("idle_busy", 128'(o_busy), 128'(0));
    chk("idle_done", 128'(o_done), 128'(0));
    chk("idle_mode", 128'(o_mode), 128'(0));
    if (c.hold) begin
      tick();
      chk("restart_busy", 128'(o_busy), 128'(1));
      i_start = 1'b0;
    end
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, "_top"}, o_top, 128'(0));
    chk({nm, "_left"}, 128'(o_left), 128'(0));
    chk({nm, "_flags"}, 128'({o_mode, o_busy, o_done, o_w_ready, o_a_ready}), 128'(0));
    chk({nm, "_stall"}, 128'(o_stall_cnt), 128'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tc[0] = '{nv: 16'd2, wb: 64'h4080_4040_4000_3F80, wstep: 16'h0, gap: 4'b1010,
              abase: 16'h3F80, astep: 16'h0, idle: 16'h0, hold: 1'b0,
              top0: {4{32'h0000_4080}}, stall: 32'd0};
    tc[1] = '{nv: 16'd0, wb: 64'h0004_0003_0002_0001, wstep: 16'h1, gap: 4'b0000,
              abase: 16'h0, astep: 16'h0, idle: 16'h0, hold: 1'b0,
              top0: 128'h00000007_00000006_00000005_00000004, stall: 32'd0};
    tc[2] = '{nv: 16'd4, wb: 64'h1111_2222_3333_4444, wstep: 16'h0100, gap: 4'b0000,
              abase: 16'h0010, astep: 16'h0001, idle: 16'h005B, hold: 1'b0,
              top0: 128'h00001411_00001311_00001211_00001111, stall: 32'd5};
    tc[3] = '{nv: 16'd3, wb: 64'hA000_B000_C000_D000, wstep: 16'h0, gap: 4'b0001,
              abase: 16'h0100, astep: 16'h0001, idle: 16'h0002, hold: 1'b1,
              top0: {4{32'h0000_A000}}, stall: 32'd1};
    rst = 1'b1;
    i_start = 1'b0;
    i_num_vec = '0;
    i_w_valid = 1'b0;
    i_w_data = '0;
    i_a_valid = 1'b0;
    i_a_data = '0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      run_case(t);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
    end
    i_num_vec = 16'd8;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    load_w(64'h4080_4040_4000_3F80, 16'h0, 4'b0000);
    repeat (4) tick();
    i_a_valid = 1'b1;
    i_a_data = {4{16'h0001}};
    repeat (3) tick();
    chk("mid_left0", 128'(o_left[15:0]), 128'(16'h0001));
    chk("mid_busy", 128'(o_busy), 128'(1));
    rst = 1'b1;
    i_a_valid = 1'b0;
    tick();
    chk_quiet("mid_reset");
    rst = 1'b0;
    tick();
    chk_quiet("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
